mem_responder: RTL

Memory-side responder for the CPU's MAR/MBR bus: a 2**ADDR_W x DATA_W word store that answers read and write requests from the CPU controller over a registered four-phase req/ack handshake with a programmable wait-state count. It sits between the CPU top level and its instruction/data path, supplying the word the CPU latches into MBR/IR. It also provides a bench/boot preload port.

---
 rtl/mem_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: req/ack word store with wait states and preload port.
// Optional MEM_PARITY_EN adds a per-word even-parity bit and the perr flag.
module mem_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              err_inj,
    output logic              perr
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] addr_q, acc_addr;
    logic [DATA_W-1:0] wdata_q, acc_wdata;
    logic we_q, acc_we, acc, wr_acc, wr_ld;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // With zero wait states the access happens on the request edge itself, so use live inputs there.
    always_comb begin
        acc = (state == S_IDLE && req && WAIT_CYCLES == 0) || (state == S_WAIT && cnt == 4'd1);
        acc_addr = state == S_IDLE ? addr : addr_q;
        acc_we = state == S_IDLE ? we : we_q;
        acc_wdata = state == S_IDLE ? wdata : wdata_q;
        wr_acc = acc && acc_we;
        wr_ld = state == S_IDLE && !req && ld_en;
        state_nx = state;
        case (state)
            S_IDLE: state_nx = req ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT: state_nx = cnt == 4'd1 ? S_RESP : S_WAIT;
            S_RESP: state_nx = req ? S_RESP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    assign busy = state != S_IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ack <= 1'b0;
            rdata <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                addr_q <= addr;
                we_q <= we;
                wdata_q <= wdata;
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (acc) begin
                ack <= 1'b1;
                if (!acc_we) rdata <= mem[acc_addr];
            end else if (state == S_RESP && !req) begin
                ack <= 1'b0;
            end
        end
    end
    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[acc_addr] <= acc_wdata;
        else if (wr_ld) mem[ld_addr] <= ld_data;
    end
`ifdef MEM_PARITY_EN
    logic par [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (wr_acc) par[acc_addr] <= ^acc_wdata ^ err_inj;
        else if (wr_ld) par[ld_addr] <= ^ld_data ^ err_inj;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr <= 1'b0;
        else if (acc && !acc_we) perr <= (^mem[acc_addr]) != par[acc_addr];
    end
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign perr = 1'b0;
`endif
endmodule
